// File: rtl/i2c_slave_pkg.sv
// Shared constants and FSM state encoding for the I2C slave.
package i2c_slave_pkg;
  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
endpackage

// File: rtl/i2c_slave_if.sv
// Bus-side and register-side signals of the I2C slave.
interface i2c_slave_if;
  logic                               scl;
  logic                               sda_in;
  logic                               sda_oe;
  logic [i2c_slave_pkg::BYTE_W-1:0]   data;
  logic                               rd_req;
  logic [i2c_slave_pkg::BYTE_W-1:0]   reg_addr;
  logic [i2c_slave_pkg::BYTE_W-1:0]   wr_data;
  logic                               wr_valid;
  logic                               busy;

  modport slave  (input  scl, sda_in, data,
                  output sda_oe, rd_req, reg_addr, wr_data, wr_valid, busy);
  modport master (output scl, sda_in, data,
                  input  sda_oe, rd_req, reg_addr, wr_data, wr_valid, busy);
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with rise/fall strobes for one asynchronous bus line.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  // Reset to 1 so an idle (pulled-up) bus produces no edges after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/i2c_slave.sv
// I2C register-style slave: address, register pointer, then write or read bytes.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h2A,
  parameter int                SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  i2c_slave_if.slave bus
);
  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .din(bus.scl), .q(scl_q), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .din(bus.sda_in), .q(sda_q), .rise(sda_rise), .fall(sda_fall));

  wire start = scl_q & sda_fall;
  wire stop  = scl_q & sda_rise;

  state_t              state_q, state_n;
  logic [3:0]          bit_cnt_q, bit_cnt_n;
  logic [BYTE_W-1:0]   shreg_q, shreg_n;
  logic [BYTE_W-1:0]   tx_q, tx_n;
  logic [BYTE_W-1:0]   reg_addr_q, reg_addr_n;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_n;
  logic                rw_q, rw_n;
  logic                sda_oe_q, sda_oe_n;
  logic                busy_q, busy_n;
  logic                rd_req_q, rd_req_n;
  logic                wr_valid_q, wr_valid_n;

  wire byte_done = (bit_cnt_q == 4'(BYTE_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shreg_q    <= shreg_n;
      tx_q       <= tx_n;
      reg_addr_q <= reg_addr_n;
      wr_data_q  <= wr_data_n;
      rw_q       <= rw_n;
      sda_oe_q   <= sda_oe_n;
      busy_q     <= busy_n;
      rd_req_q   <= rd_req_n;
      wr_valid_q <= wr_valid_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shreg_n    = shreg_q;
    tx_n       = tx_q;
    reg_addr_n = reg_addr_q;
    wr_data_n  = wr_data_q;
    rw_n       = rw_q;
    sda_oe_n   = sda_oe_q;
    busy_n     = busy_q;
    rd_req_n   = 1'b0;
    wr_valid_n = 1'b0;

    // Pointer advances the cycle after the write strobe, so the strobe sees the old value.
    if (wr_valid_q) reg_addr_n = reg_addr_q + 8'd1;

    if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (scl_rise) begin
      shreg_n = {shreg_q[BYTE_W-2:0], sda_q};
      if (state_q inside {ADDR, REG, WDATA, RDATA}) bit_cnt_n = bit_cnt_q + 4'd1;
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (byte_done) begin
          bit_cnt_n = '0;
          if (shreg_q[BYTE_W-1:1] == SLAVE_ADDR) begin
            state_n  = ADDR_ACK;
            sda_oe_n = 1'b1;
            busy_n   = 1'b1;
            rw_n     = shreg_q[0];
          end else begin
            state_n = IGNORE;
            busy_n  = 1'b0;
          end
        end
        ADDR_ACK: begin
          bit_cnt_n = '0;
          if (rw_q) begin
            state_n  = RDATA;
            tx_n     = bus.data;
            rd_req_n = 1'b1;
            sda_oe_n = ~bus.data[BYTE_W-1];
          end else begin
            state_n  = REG;
            sda_oe_n = 1'b0;
          end
        end
        REG: if (byte_done) begin
          bit_cnt_n  = '0;
          reg_addr_n = shreg_q;
          state_n    = REG_ACK;
          sda_oe_n   = 1'b1;
        end
        REG_ACK, WDATA_ACK: begin
          state_n  = WDATA;
          sda_oe_n = 1'b0;
        end
        WDATA: if (byte_done) begin
          bit_cnt_n  = '0;
          wr_data_n  = shreg_q;
          wr_valid_n = 1'b1;
          state_n    = WDATA_ACK;
          sda_oe_n   = 1'b1;
        end
        RDATA: if (byte_done) begin
          bit_cnt_n = '0;
          state_n   = RDATA_ACK;
          sda_oe_n  = 1'b0;
        end else begin
          tx_n     = {tx_q[BYTE_W-2:0], 1'b0};
          sda_oe_n = ~tx_q[BYTE_W-2];
        end
        RDATA_ACK: begin
          // shreg_q[0] holds the master's ACK bit sampled on the 9th rising edge.
          bit_cnt_n = '0;
          if (!shreg_q[0]) begin
            state_n  = RDATA;
            tx_n     = bus.data;
            rd_req_n = 1'b1;
            sda_oe_n = ~bus.data[BYTE_W-1];
          end else begin
            state_n  = IGNORE;
            sda_oe_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.rd_req   = rd_req_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.wr_data  = wr_data_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench: a behavioural I2C master drives transactions from a vector table.
module tb_i2c_slave;
  import i2c_slave_pkg::*;

  localparam int T = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] rd_byte = 8'h00;

  always #5 clk = ~clk;

  i2c_slave_if bif();
  wire line = m_sda & ~bif.sda_oe;
  assign bif.scl    = m_scl;
  assign bif.sda_in = line;
  assign bif.data   = rd_byte;

  i2c_slave #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bif));

  int n_chk = 0, n_pass = 0, wr_cnt = 0, rd_cnt = 0;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_exp_t;
  wr_exp_t wr_q[$];

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] ra;
    logic [7:0] d0, d1;
    int         n;
    logic [7:0] ra_after;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    wr_exp_t e;
    if (!rst) begin
      if (bif.rd_req) rd_cnt++;
      if (bif.wr_valid) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_expected", 32'(wr_q.size()), 32'd1);
        else begin
          e = wr_q.pop_front();
          chk("wr_reg_addr", {24'd0, bif.reg_addr}, {24'd0, e.a});
          chk("wr_data", {24'd0, bif.wr_data}, {24'd0, e.d});
        end
      end
    end
  end

  task automatic wait_t();
    repeat (T) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; wait_t();
    m_scl = 1'b0; wait_t();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_t();
    m_scl = 1'b1; wait_t();
    m_sda = 1'b1; wait_t();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_t();
    m_scl = 1'b1; wait_t();
    m_scl = 1'b0; wait_t();
  endtask

  task automatic get_ack(output logic ack);
    m_sda = 1'b1; wait_t();
    m_scl = 1'b1; wait_t();
    ack = ~line;
    m_scl = 1'b0; wait_t();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack, input logic [7:0] nxt);
    m_sda = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_scl = 1'b1; wait_t();
      b = {b[6:0], line};
      m_scl = 1'b0; wait_t();
    end
    rd_byte = nxt;
    m_sda = ~mack; wait_t();
    m_scl = 1'b1;  wait_t();
    m_scl = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_sda = 1'b1;
    wait_t();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, exp_ack;
    logic [7:0] b, d;
    int         w0, r0, exp_wr, exp_rd;

    vecs[0] = '{addr: 7'h2A, rw: 1'b0, ra: 8'h10, d0: 8'hA5, d1: 8'h00, n: 1, ra_after: 8'h11};
    vecs[1] = '{addr: 7'h2B, rw: 1'b0, ra: 8'h10, d0: 8'hA5, d1: 8'h00, n: 1, ra_after: 8'h11};
    vecs[2] = '{addr: 7'h2A, rw: 1'b1, ra: 8'h00, d0: 8'h3C, d1: 8'h00, n: 1, ra_after: 8'h11};
    vecs[3] = '{addr: 7'h2A, rw: 1'b1, ra: 8'h00, d0: 8'h81, d1: 8'h7E, n: 2, ra_after: 8'h11};
    vecs[4] = '{addr: 7'h2A, rw: 1'b0, ra: 8'hFF, d0: 8'h11, d1: 8'h22, n: 2, ra_after: 8'h01};

    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda_oe", {31'd0, bif.sda_oe}, 0);
    chk("rst_busy", {31'd0, bif.busy}, 0);
    chk("rst_reg_addr", {24'd0, bif.reg_addr}, 0);
    chk("rst_wr_data", {24'd0, bif.wr_data}, 0);
    chk("rst_pulses", {30'd0, bif.rd_req, bif.wr_valid}, 0);
    rst = 1'b0;
    wait_t();

    for (int i = 0; i < 5; i++) begin
      exp_ack = (vecs[i].addr == 7'h2A);
      exp_wr  = (exp_ack && !vecs[i].rw) ? vecs[i].n : 0;
      exp_rd  = (exp_ack &&  vecs[i].rw) ? vecs[i].n : 0;
      w0 = wr_cnt;
      r0 = rd_cnt;
      rd_byte = vecs[i].d0;
      i2c_start();
      send_byte({vecs[i].addr, vecs[i].rw}, ack);
      chk($sformatf("v%0d_addr_ack", i), {31'd0, ack}, {31'd0, exp_ack});
      chk($sformatf("v%0d_busy", i), {31'd0, bif.busy}, {31'd0, exp_ack});
      if (ack) begin
        if (!vecs[i].rw) begin
          send_byte(vecs[i].ra, ack);
          chk($sformatf("v%0d_reg_ack", i), {31'd0, ack}, 1);
          for (int k = 0; k < vecs[i].n; k++) begin
            d = (k == 0) ? vecs[i].d0 : vecs[i].d1;
            wr_q.push_back('{a: vecs[i].ra + 8'(k), d: d});
            send_byte(d, ack);
            chk($sformatf("v%0d_data_ack%0d", i, k), {31'd0, ack}, 1);
          end
        end else begin
          for (int k = 0; k < vecs[i].n; k++) begin
            recv_byte(b, k < vecs[i].n - 1, vecs[i].d1);
            chk($sformatf("v%0d_rd_byte%0d", i, k), {24'd0, b},
                {24'd0, (k == 0) ? vecs[i].d0 : vecs[i].d1});
          end
        end
      end
      i2c_stop();
      chk($sformatf("v%0d_busy_stop", i), {31'd0, bif.busy}, 0);
      chk($sformatf("v%0d_oe_stop", i), {31'd0, bif.sda_oe}, 0);
      chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - w0), 32'(exp_wr));
      chk($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - r0), 32'(exp_rd));
      chk($sformatf("v%0d_reg_after", i), {24'd0, bif.reg_addr}, {24'd0, vecs[i].ra_after});
    end

    // STOP in the middle of a data byte: the partial byte must be discarded.
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'h54, ack);
    chk("abort_addr_ack", {31'd0, ack}, 1);
    send_byte(8'h20, ack);
    chk("abort_reg_ack", {31'd0, ack}, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    chk("abort_busy", {31'd0, bif.busy}, 0);
    chk("abort_oe", {31'd0, bif.sda_oe}, 0);

    // Reset in the middle of the address byte, then the rest of the byte is not acknowledged.
    i2c_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_mid_oe", {31'd0, bif.sda_oe}, 0);
    chk("rst_mid_busy", {31'd0, bif.busy}, 0);
    chk("rst_mid_reg_addr", {24'd0, bif.reg_addr}, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    get_ack(ack);
    chk("rst_mid_no_ack", {31'd0, ack}, 0);
    i2c_stop();
    chk("abort_wr_cnt", 32'(wr_cnt - w0), 0);
    chk("wr_queue_drained", 32'(wr_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
